// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the CPU datapath.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        con;
  logic        stop;
  logic [2:0]  gr_sel;
  logic [2:0]  reg_ctl;
  logic [2:0]  pc_ctl;
  logic [4:0]  mem_ctl;
  logic [3:0]  alu_ctl;
  logic [3:0]  hilo_ctl;
  logic [4:0]  misc_ctl;
  logic [4:0]  opcode;
  logic        run;

  modport master (
    input  ir, con, stop,
    output gr_sel, reg_ctl, pc_ctl, mem_ctl, alu_ctl, hilo_ctl, misc_ctl, opcode, run
  );

  modport slave (
    output ir, con, stop,
    input  gr_sel, reg_ctl, pc_ctl, mem_ctl, alu_ctl, hilo_ctl, misc_ctl, opcode, run
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, decode ir[31:27], per-class execute steps,
// then back to T0 or into HALT. All control outputs are registered Moore outputs.
module control_sequencer #(
  parameter logic [4:0]  ADD_OP = 5'b00011,
  parameter int unsigned MAX_T  = 7
) (
  input  logic                 clock,
  input  logic                 clear,
  control_sequencer_if.master  bus
);

  localparam int unsigned STEP_W = 3;
  localparam int unsigned OP_W   = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [2:0] GRA = 3'b100, GRB = 3'b010, GRC = 3'b001;
  localparam logic [2:0] REG_RIN = 3'b100, REG_ROUT = 3'b010, REG_BAOUT = 3'b001;
  localparam logic [2:0] PC_OUT = 3'b100, PC_IN = 3'b010, PC_INC = 3'b001;
  localparam logic [4:0] MEM_MARIN  = 5'b10000, MEM_MDRIN = 5'b01000;
  localparam logic [4:0] MEM_MDROUT = 5'b00100, MEM_READ  = 5'b00010, MEM_WRITE = 5'b00001;
  localparam logic [3:0] ALU_YIN = 4'b1000, ALU_ZIN = 4'b0100, ALU_ZHI = 4'b0010, ALU_ZLO = 4'b0001;
  localparam logic [3:0] HL_HIIN = 4'b1000, HL_HIOUT = 4'b0100, HL_LOIN = 4'b0010, HL_LOOUT = 4'b0001;
  localparam logic [4:0] MS_IRIN  = 5'b10000, MS_COUT  = 5'b01000, MS_CONIN = 5'b00100;
  localparam logic [4:0] MS_OUTIN = 5'b00010, MS_INOUT = 5'b00001;

  typedef enum logic [1:0] {S_RESET, S_EXEC, S_HALT} state_t;

  typedef struct packed {
    logic [2:0]      gr_sel;
    logic [2:0]      reg_ctl;
    logic [2:0]      pc_ctl;
    logic [4:0]      mem_ctl;
    logic [3:0]      alu_ctl;
    logic [3:0]      hilo_ctl;
    logic [4:0]      misc_ctl;
    logic [OP_W-1:0] opcode;
    logic            run;
  } ctl_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [OP_W-1:0]     op_q, op_d, cur_op;
  logic                stop_pend_q, stop_pend_d;
  logic                last;
  ctl_t                ctl_q, ctl_d;
  logic                unused_ir;

  assign unused_ir = ^bus.ir[26:0];

  // Final execute step of each instruction class; nop and undefined codes end at T2.
  function automatic logic [STEP_W-1:0] last_step(input logic [OP_W-1:0] op);
    logic [STEP_W-1:0] ls;
    ls = 3'd2;
    if (op inside {[OP_ADD:OP_SHL], [OP_ADDI:OP_ORI], OP_LDI}) ls = 3'd5;
    else if (op inside {OP_LD, OP_ST})                         ls = 3'd7;
    else if (op inside {OP_MUL, OP_DIV, OP_BR})                ls = 3'd6;
    else if (op inside {OP_NEG, OP_NOT})                       ls = 3'd4;
    else if (op inside {OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO}) ls = 3'd3;
    return ls;
  endfunction

  // Control word for a given state/step/class; at most one bus driver per step.
  function automatic ctl_t decode(input state_t st, input logic [STEP_W-1:0] step,
                                  input logic [OP_W-1:0] op, input logic c);
    ctl_t d;
    d        = '0;
    d.opcode = ADD_OP;
    if (st == S_EXEC) begin
      d.run = 1'b1;
      case (step)
        3'd0: begin
          d.pc_ctl  = PC_OUT | PC_INC;
          d.mem_ctl = MEM_MARIN;
          d.alu_ctl = ALU_ZIN;
        end
        3'd1: begin
          d.alu_ctl = ALU_ZLO;
          d.pc_ctl  = PC_IN;
          d.mem_ctl = MEM_READ | MEM_MDRIN;
        end
        3'd2: begin
          d.mem_ctl  = MEM_MDROUT;
          d.misc_ctl = MS_IRIN;
        end
        default: begin
          if (op inside {[OP_ADD:OP_SHL], [OP_ADDI:OP_ORI]}) begin
            case (step)
              3'd3: begin d.gr_sel = GRB; d.reg_ctl = REG_ROUT; d.alu_ctl = ALU_YIN; end
              3'd4: begin
                d.alu_ctl = ALU_ZIN;
                if (op inside {[OP_ADD:OP_SHL]}) begin
                  d.gr_sel  = GRC;
                  d.reg_ctl = REG_ROUT;
                  d.opcode  = op;
                end else begin
                  d.misc_ctl = MS_COUT;
                  d.opcode   = (op == OP_ANDI) ? OP_AND : (op == OP_ORI) ? OP_OR : ADD_OP;
                end
              end
              3'd5: begin d.alu_ctl = ALU_ZLO; d.gr_sel = GRA; d.reg_ctl = REG_RIN; end
              default: ;
            endcase
          end else if (op inside {OP_LD, OP_LDI, OP_ST}) begin
            case (step)
              3'd3: begin d.gr_sel = GRB; d.reg_ctl = REG_BAOUT; d.alu_ctl = ALU_YIN; end
              3'd4: begin d.misc_ctl = MS_COUT; d.alu_ctl = ALU_ZIN; end
              3'd5: begin
                d.alu_ctl = ALU_ZLO;
                if (op == OP_LDI) begin
                  d.gr_sel  = GRA;
                  d.reg_ctl = REG_RIN;
                end else begin
                  d.mem_ctl = MEM_MARIN;
                end
              end
              3'd6: begin
                if (op == OP_ST) begin
                  d.gr_sel  = GRA;
                  d.reg_ctl = REG_ROUT;
                  d.mem_ctl = MEM_MDRIN;
                end else begin
                  d.mem_ctl = MEM_READ | MEM_MDRIN;
                end
              end
              3'd7: begin
                if (op == OP_ST) begin
                  d.mem_ctl = MEM_WRITE;
                end else begin
                  d.mem_ctl = MEM_MDROUT;
                  d.gr_sel  = GRA;
                  d.reg_ctl = REG_RIN;
                end
              end
              default: ;
            endcase
          end else if (op inside {OP_MUL, OP_DIV}) begin
            case (step)
              3'd3: begin d.gr_sel = GRA; d.reg_ctl = REG_ROUT; d.alu_ctl = ALU_YIN; end
              3'd4: begin d.gr_sel = GRB; d.reg_ctl = REG_ROUT; d.alu_ctl = ALU_ZIN; d.opcode = op; end
              3'd5: begin d.alu_ctl = ALU_ZLO; d.hilo_ctl = HL_LOIN; end
              3'd6: begin d.alu_ctl = ALU_ZHI; d.hilo_ctl = HL_HIIN; end
              default: ;
            endcase
          end else if (op inside {OP_NEG, OP_NOT}) begin
            case (step)
              3'd3: begin d.gr_sel = GRB; d.reg_ctl = REG_ROUT; d.alu_ctl = ALU_ZIN; d.opcode = op; end
              3'd4: begin d.alu_ctl = ALU_ZLO; d.gr_sel = GRA; d.reg_ctl = REG_RIN; end
              default: ;
            endcase
          end else if (op == OP_BR) begin
            case (step)
              3'd3: begin d.gr_sel = GRA; d.reg_ctl = REG_ROUT; d.misc_ctl = MS_CONIN; end
              3'd4: begin d.pc_ctl = PC_OUT; d.alu_ctl = ALU_YIN; end
              3'd5: begin d.misc_ctl = MS_COUT; d.alu_ctl = ALU_ZIN; end
              3'd6: begin d.alu_ctl = ALU_ZLO; d.pc_ctl = c ? PC_IN : 3'b000; end
              default: ;
            endcase
          end else if (step == 3'd3) begin
            case (op)
              OP_JR:   begin d.gr_sel = GRA; d.reg_ctl = REG_ROUT; d.pc_ctl = PC_IN; end
              OP_IN:   begin d.misc_ctl = MS_INOUT; d.gr_sel = GRA; d.reg_ctl = REG_RIN; end
              OP_OUT:  begin d.gr_sel = GRA; d.reg_ctl = REG_ROUT; d.misc_ctl = MS_OUTIN; end
              OP_MFHI: begin d.hilo_ctl = HL_HIOUT; d.gr_sel = GRA; d.reg_ctl = REG_RIN; end
              OP_MFLO: begin d.hilo_ctl = HL_LOOUT; d.gr_sel = GRA; d.reg_ctl = REG_RIN; end
              default: ;
            endcase
          end
        end
      endcase
    end
    return d;
  endfunction

  // Next state/step; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    op_d        = op_q;
    stop_pend_d = stop_pend_q | bus.stop;
    cur_op      = op_q;
    last        = 1'b0;
    case (state_q)
      S_RESET: begin
        state_d     = S_EXEC;
        step_d      = '0;
        stop_pend_d = 1'b0;
      end
      S_EXEC: begin
        if (step_q == 3'd2) begin
          cur_op = bus.ir[31:27];
          op_d   = cur_op;
        end
        last = (step_q >= last_step(cur_op)) || (step_q == STEP_W'(MAX_T));
        if (step_q == 3'd2 && cur_op == OP_HALT) begin
          state_d = S_HALT;
        end else if (last) begin
          state_d     = stop_pend_d ? S_HALT : S_EXEC;
          step_d      = '0;
          stop_pend_d = 1'b0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    ctl_d = decode(state_d, step_d, op_d, bus.con);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= S_RESET;
      step_q      <= '0;
      op_q        <= '0;
      stop_pend_q <= 1'b0;
      ctl_q       <= '{opcode: ADD_OP, default: '0};
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      op_q        <= op_d;
      stop_pend_q <= stop_pend_d;
      ctl_q       <= ctl_d;
    end
  end

  assign bus.gr_sel   = ctl_q.gr_sel;
  assign bus.reg_ctl  = ctl_q.reg_ctl;
  assign bus.pc_ctl   = ctl_q.pc_ctl;
  assign bus.mem_ctl  = ctl_q.mem_ctl;
  assign bus.alu_ctl  = ctl_q.alu_ctl;
  assign bus.hilo_ctl = ctl_q.hilo_ctl;
  assign bus.misc_ctl = ctl_q.misc_ctl;
  assign bus.opcode   = ctl_q.opcode;
  assign bus.run      = ctl_q.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues per-cycle expected control words,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_control_sequencer;

  localparam logic [4:0] ADD = 5'b00011;

  typedef struct {
    logic [32:0] v;
    string       tag;
  } exp_t;

  logic clock;
  logic clear;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  control_sequencer_if bus();

  control_sequencer #(.ADD_OP(5'b00011), .MAX_T(7)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [32:0] cv(input logic [2:0] gr, input logic [2:0] rg,
                                     input logic [2:0] pc, input logic [4:0] mem,
                                     input logic [3:0] alu, input logic [3:0] hl,
                                     input logic [4:0] ms, input logic [4:0] opc);
    return {gr, rg, pc, mem, alu, hl, ms, opc, 1'b1};
  endfunction

  function automatic logic [32:0] idle();
    return {27'b0, ADD, 1'b0};
  endfunction

  task automatic push(input string tag, input logic [32:0] v);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Starts an instruction in T0 and queues the three fetch words.
  task automatic begin_instr(input string tag, input logic [31:0] instr, input logic c);
    bus.ir  = instr;
    bus.con = c;
    push({tag, "_T0"}, cv(3'b000, 3'b000, 3'b101, 5'b10000, 4'b0100, 4'b0000, 5'b00000, ADD));
    push({tag, "_T1"}, cv(3'b000, 3'b000, 3'b010, 5'b01010, 4'b0001, 4'b0000, 5'b00000, ADD));
    push({tag, "_T2"}, cv(3'b000, 3'b000, 3'b000, 5'b00100, 4'b0000, 4'b0000, 5'b10000, ADD));
  endtask

  task automatic do_reset(input string tag);
    clear = 1'b0;
    push({tag, "_clr"}, idle());
    tick(1);
    clear = 1'b1;
    push({tag, "_rel"}, idle());
    tick(1);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [32:0] act;
      e   = exp_q.pop_front();
      act = {bus.gr_sel, bus.reg_ctl, bus.pc_ctl, bus.mem_ctl, bus.alu_ctl,
             bus.hilo_ctl, bus.misc_ctl, bus.opcode, bus.run};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b_%b_%b_%b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b_%b_%b_%b",
                 e.tag, act[32:30], act[29:27], act[26:24], act[23:19], act[18:15],
                 act[14:11], act[10:6], act[5:1], act[0],
                 e.v[32:30], e.v[29:27], e.v[26:24], e.v[23:19], e.v[18:15],
                 e.v[14:11], e.v[10:6], e.v[5:1], e.v[0]);
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    clear    = 1'b0;
    bus.ir   = '0;
    bus.con  = 1'b0;
    bus.stop = 1'b0;
    tick(1);
    do_reset("reset");

    // add R1,R2,R3
    begin_instr("add", 32'h18918000, 1'b0);
    push("add_T3", cv(3'b010, 3'b010, 3'b000, 5'b00000, 4'b1000, 4'b0000, 5'b00000, ADD));
    push("add_T4", cv(3'b001, 3'b010, 3'b000, 5'b00000, 4'b0100, 4'b0000, 5'b00000, 5'b00011));
    push("add_T5", cv(3'b100, 3'b100, 3'b000, 5'b00000, 4'b0001, 4'b0000, 5'b00000, ADD));
    tick(6);

    // ld R1,0x55: eight cycles, next T0 follows directly
    begin_instr("ld", 32'h00800055, 1'b0);
    push("ld_T3", cv(3'b010, 3'b001, 3'b000, 5'b00000, 4'b1000, 4'b0000, 5'b00000, ADD));
    push("ld_T4", cv(3'b000, 3'b000, 3'b000, 5'b00000, 4'b0100, 4'b0000, 5'b01000, ADD));
    push("ld_T5", cv(3'b000, 3'b000, 3'b000, 5'b10000, 4'b0001, 4'b0000, 5'b00000, ADD));
    push("ld_T6", cv(3'b000, 3'b000, 3'b000, 5'b01010, 4'b0000, 4'b0000, 5'b00000, ADD));
    push("ld_T7", cv(3'b100, 3'b100, 3'b000, 5'b00100, 4'b0000, 4'b0000, 5'b00000, ADD));
    tick(8);

    begin_instr("ldi", 32'h08800055, 1'b0);
    push("ldi_T3", cv(3'b010, 3'b001, 3'b000, 5'b00000, 4'b1000, 4'b0000, 5'b00000, ADD));
    push("ldi_T4", cv(3'b000, 3'b000, 3'b000, 5'b00000, 4'b0100, 4'b0000, 5'b01000, ADD));
    push("ldi_T5", cv(3'b100, 3'b100, 3'b000, 5'b00000, 4'b0001, 4'b0000, 5'b00000, ADD));
    tick(6);

    begin_instr("st", 32'h10800055, 1'b0);
    push("st_T3", cv(3'b010, 3'b001, 3'b000, 5'b00000, 4'b1000, 4'b0000, 5'b00000, ADD));
    push("st_T4", cv(3'b000, 3'b000, 3'b000, 5'b00000, 4'b0100, 4'b0000, 5'b01000, ADD));
    push("st_T5", cv(3'b000, 3'b000, 3'b000, 5'b10000, 4'b0001, 4'b0000, 5'b00000, ADD));
    push("st_T6", cv(3'b100, 3'b010, 3'b000, 5'b01000, 4'b0000, 4'b0000, 5'b00000, ADD));
    push("st_T7", cv(3'b000, 3'b000, 3'b000, 5'b00001, 4'b0000, 4'b0000, 5'b00000, ADD));
    tick(8);

    begin_instr("andi", 32'h68800007, 1'b0);
    push("andi_T3", cv(3'b010, 3'b010, 3'b000, 5'b00000, 4'b1000, 4'b0000, 5'b00000, ADD));
    push("andi_T4", cv(3'b000, 3'b000, 3'b000, 5'b00000, 4'b0100, 4'b0000, 5'b01000, 5'b00101));
    push("andi_T5", cv(3'b100, 3'b100, 3'b000, 5'b00000, 4'b0001, 4'b0000, 5'b00000, ADD));
    tick(6);

    begin_instr("mul", 32'h80000000, 1'b0);
    push("mul_T3", cv(3'b100, 3'b010, 3'b000, 5'b00000, 4'b1000, 4'b0000, 5'b00000, ADD));
    push("mul_T4", cv(3'b010, 3'b010, 3'b000, 5'b00000, 4'b0100, 4'b0000, 5'b00000, 5'b10000));
    push("mul_T5", cv(3'b000, 3'b000, 3'b000, 5'b00000, 4'b0001, 4'b0010, 5'b00000, ADD));
    push("mul_T6", cv(3'b000, 3'b000, 3'b000, 5'b00000, 4'b0010, 4'b1000, 5'b00000, ADD));
    tick(7);

    begin_instr("neg", 32'h88000000, 1'b0);
    push("neg_T3", cv(3'b010, 3'b010, 3'b000, 5'b00000, 4'b0100, 4'b0000, 5'b00000, 5'b10001));
    push("neg_T4", cv(3'b100, 3'b100, 3'b000, 5'b00000, 4'b0001, 4'b0000, 5'b00000, ADD));
    tick(5);

    // br with con=0 then con=1: only the taken branch loads PC in T6
    for (int c = 0; c < 2; c++) begin
      begin_instr(c == 0 ? "br0" : "br1", 32'h98000000, c[0]);
      push("br_T3", cv(3'b100, 3'b010, 3'b000, 5'b00000, 4'b0000, 4'b0000, 5'b00100, ADD));
      push("br_T4", cv(3'b000, 3'b000, 3'b100, 5'b00000, 4'b1000, 4'b0000, 5'b00000, ADD));
      push("br_T5", cv(3'b000, 3'b000, 3'b000, 5'b00000, 4'b0100, 4'b0000, 5'b01000, ADD));
      push(c == 0 ? "br0_T6" : "br1_T6",
           cv(3'b000, 3'b000, c == 0 ? 3'b000 : 3'b010, 5'b00000, 4'b0001, 4'b0000, 5'b00000, ADD));
      tick(7);
    end

    begin_instr("jr", 32'hA0000000, 1'b0);
    push("jr_T3", cv(3'b100, 3'b010, 3'b010, 5'b00000, 4'b0000, 4'b0000, 5'b00000, ADD));
    tick(4);
    begin_instr("in", 32'hB0000000, 1'b0);
    push("in_T3", cv(3'b100, 3'b100, 3'b000, 5'b00000, 4'b0000, 4'b0000, 5'b00001, ADD));
    tick(4);
    begin_instr("out", 32'hB8000000, 1'b0);
    push("out_T3", cv(3'b100, 3'b010, 3'b000, 5'b00000, 4'b0000, 4'b0000, 5'b00010, ADD));
    tick(4);
    begin_instr("mfhi", 32'hC0000000, 1'b0);
    push("mfhi_T3", cv(3'b100, 3'b100, 3'b000, 5'b00000, 4'b0000, 4'b0100, 5'b00000, ADD));
    tick(4);
    begin_instr("mflo", 32'hC8000000, 1'b0);
    push("mflo_T3", cv(3'b100, 3'b100, 3'b000, 5'b00000, 4'b0000, 4'b0001, 5'b00000, ADD));
    tick(4);

    // nop ends after T2
    begin_instr("nop", 32'hD0000000, 1'b0);
    tick(3);

    // clear pulled low mid-T4 of add: outputs must drop within the cycle
    begin_instr("abort", 32'h18918000, 1'b0);
    push("abort_T3", cv(3'b010, 3'b010, 3'b000, 5'b00000, 4'b1000, 4'b0000, 5'b00000, ADD));
    tick(4);
    #1;
    do_reset("abort");

    // stop pulsed during T4 of add: add completes, then HALT
    begin_instr("stop", 32'h18918000, 1'b0);
    push("stop_T3", cv(3'b010, 3'b010, 3'b000, 5'b00000, 4'b1000, 4'b0000, 5'b00000, ADD));
    push("stop_T4", cv(3'b001, 3'b010, 3'b000, 5'b00000, 4'b0100, 4'b0000, 5'b00000, 5'b00011));
    push("stop_T5", cv(3'b100, 3'b100, 3'b000, 5'b00000, 4'b0001, 4'b0000, 5'b00000, ADD));
    for (int i = 0; i < 3; i++) push("stop_halt", idle());
    tick(4);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    tick(4);
    do_reset("unhalt");

    // halt opcode: run falls after T2 and stays low
    begin_instr("halt", 32'hD8000000, 1'b0);
    for (int i = 0; i < 4; i++) push("halt_hold", idle());
    tick(7);

    tick(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
